// File: rtl/data_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_if
// Brief    : CPU data-SRAM request/response bundle. The requester (EX/MEM
//            side of the pipeline) drives the request; the responder returns
//            registered read data and a stall request.
// Revision : 1.0
// ============================================================================
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Brief    : Word-organised data RAM with byte-lane writes, a registered read
//            port and a programmable wait-state counter that stalls the
//            pipeline before each access is performed.
// Revision : 1.0
// ============================================================================
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  data_sram_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  logic [31:0]           mem [DEPTH];
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  wait_done;
  logic                  access;
  logic                  do_read;
  logic                  do_write;
  logic                  unused_addr_bits;

  // Byte offset and bits above the RAM depth are ignored, so addresses alias.
  assign idx = bus.data_sram_addr[ADDR_WIDTH+1:2];

  if (ADDR_WIDTH < 30) begin : g_addr_hi
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_WIDTH+2], bus.data_sram_addr[1:0]};
  end else begin : g_addr_full
    assign unused_addr_bits = ^bus.data_sram_addr[1:0];
  end

  // cnt never exceeds WAIT_MAX, so equality marks the end of the wait.
  // Gating with rst keeps a request held through reset from being performed.
  assign wait_done    = (cnt == WAIT_MAX);
  assign access       = rst && bus.data_sram_en && wait_done;
  assign do_read      = access && (bus.data_sram_wen == 4'b0000);
  assign do_write     = access && (bus.data_sram_wen != 4'b0000);
  assign bus.stallreq = rst && bus.data_sram_en && !wait_done;

  // Wait-state counter: advance while a request waits, clear on access or idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (bus.data_sram_en && !wait_done) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  // Registered read port: only a performed read updates rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_sram_rdata <= 32'd0;
    end else if (do_read) begin
      bus.data_sram_rdata <= mem[idx];
    end
  end

  // Byte-lane write into the (non-reset) storage array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_write && bus.data_sram_wen[i]) begin
        mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_responder
// Brief    : Self-checking bench. Two responders (0 and 3 wait states) are
//            driven one request at a time; a reference memory predicts read
//            data, a scoreboard queue carries it to a monitor process.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_sram_if if0 ();
  data_sram_if if1 ();

  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  data_sram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  logic        en    [2];
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  wire  [31:0] rd    [2];
  wire         stl   [2];

  assign if0.data_sram_en    = en[0];
  assign if0.data_sram_wen   = wen[0];
  assign if0.data_sram_addr  = addr[0];
  assign if0.data_sram_wdata = wdata[0];
  assign if1.data_sram_en    = en[1];
  assign if1.data_sram_wen   = wen[1];
  assign if1.data_sram_addr  = addr[1];
  assign if1.data_sram_wdata = wdata[1];
  assign rd[0]  = if0.data_sram_rdata;
  assign rd[1]  = if1.data_sram_rdata;
  assign stl[0] = if0.stallreq;
  assign stl[1] = if1.stallreq;

  typedef struct {
    int          d;
    logic [31:0] v;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mm [int];
  logic [31:0] exp_rd [2];
  int          waits [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  // Reference word address: byte address divided by four, wrapped to depth.
  function automatic int key_of(input int d, input logic [31:0] a);
    return d * 4096 + int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] mk_addr(input int wi);
    int idx;
    idx = (wi * 97 + 3) % 1024;
    return (32'($urandom_range(0, 1023)) << 12) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
  endfunction

  // Monitor: whenever a performed read is pending, rdata must show it now.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("rdata_dut%0d", e.d), rd[e.d], e.v);
    end
  end

  // Issue one request on responder d; starts and ends at a falling edge.
  task automatic req(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    int          key;
    logic [31:0] tmp;
    en[1-d] = 1'b0;
    en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
    for (int k = 0; k < waits[d]; k++) begin
      #1;
      chk("stall_on", 32'(stl[d]), 32'd1);
      chk("rdata_hold_wait", rd[d], exp_rd[d]);
      @(negedge clk);
    end
    #1;
    chk("stall_off", 32'(stl[d]), 32'd0);
    chk("rdata_hold_pre", rd[d], exp_rd[d]);
    @(posedge clk);
    #1;
    key = key_of(d, a);
    if (w == 4'b0000) begin
      exp_rd[d] = mm[key];
      sbq.push_back('{d: d, v: mm[key]});
    end else begin
      tmp = mm.exists(key) ? mm[key] : 32'd0;
      for (int i = 0; i < 4; i++)
        if (w[i]) tmp[8*i +: 8] = wd[8*i +: 8];
      mm[key] = tmp;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en[0] = 1'b0;
    en[1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("idle_stall0", 32'(stl[0]), 32'd0);
      chk("idle_stall3", 32'(stl[1]), 32'd0);
      chk("idle_rdata0", rd[0], exp_rd[0]);
      chk("idle_rdata3", rd[1], exp_rd[1]);
      @(negedge clk);
    end
  endtask

  // Hard bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    waits[0] = 0; waits[1] = 3;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; wen[d] = 4'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end

    // Reset state and idle.
    #1;
    chk("reset_rdata0", rd[0], 32'd0);
    chk("reset_rdata3", rd[1], 32'd0);
    chk("reset_stall3", 32'(stl[1]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(5);

    // Zero wait states: word write, read-after-write, byte lanes, misaligned.
    req(0, 4'hF, 32'h10, 32'hDEADBEEF);
    req(0, 4'h0, 32'h10, 32'h0);
    req(0, 4'hF, 32'h20, 32'h11223344);
    req(0, 4'b0101, 32'h20, 32'hAABBCCDD);
    req(0, 4'h0, 32'h20, 32'h0);
    req(0, 4'h0, 32'h23, 32'h0);
    idle(2);
    chk("lanes_model", mm[key_of(0, 32'h20)], 32'h11BB33DD);

    // Three wait states.
    req(1, 4'hF, 32'h10, 32'hDEADBEEF);
    idle(1);
    req(1, 4'h0, 32'h10, 32'h0);
    idle(1);

    // Flush mid-wait: two stall cycles then withdraw; nothing is written.
    en[0] = 1'b0;
    en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h10; wdata[1] = 32'h12345678;
    #1; chk("flush_stall_c0", 32'(stl[1]), 32'd1);
    @(negedge clk);
    #1; chk("flush_stall_c1", 32'(stl[1]), 32'd1);
    @(negedge clk);
    en[1] = 1'b0;
    #1; chk("flush_stall_drop", 32'(stl[1]), 32'd0);
    @(negedge clk);
    idle(1);
    req(1, 4'h0, 32'h10, 32'h0);
    idle(1);

    // Reset asserted during the second stall cycle of a read.
    en[0] = 1'b0;
    en[1] = 1'b1; wen[1] = 4'h0; addr[1] = 32'h10; wdata[1] = 32'h0;
    #1; chk("rstw_stall_c0", 32'(stl[1]), 32'd1);
    @(negedge clk);
    #2; rst = 1'b0;
    #1;
    chk("rstw_stall", 32'(stl[1]), 32'd0);
    chk("rstw_rdata3", rd[1], 32'd0);
    chk("rstw_rdata0", rd[0], 32'd0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    @(negedge clk);
    #1; chk("rstw_rdata3_held", rd[1], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req(1, 4'h0, 32'h10, 32'h0);

    // Randomised traffic against the reference memory on both responders.
    for (int d = 0; d < 2; d++) begin
      for (int wi = 0; wi < 8; wi++)
        req(d, 4'hF, mk_addr(wi), $urandom);
      for (int n = 0; n < 40; n++) begin
        int          wi;
        logic [3:0]  w;
        wi = $urandom_range(0, 7);
        w  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        req(d, w, mk_addr(wi), $urandom);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      for (int wi = 0; wi < 8; wi++)
        req(d, 4'h0, mk_addr(wi), 32'h0);
    end

    idle(3);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface. EX issues requests (en/wen/addr/wdata); the MEM stage consumes rdata one pipeline step later.
- Word-organised synchronous RAM with byte-lane writes and a registered read port.
- Programmable wait-state counter that raises a stall request into the pipeline stall controller, so the CPU can be exercised against slow memory.
- Used as the data memory in simulation and SoC top.

Parameters:
- ADDR_WIDTH, 10, word-index width; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 0, stall cycles inserted before each access is performed; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_sram_en  input  1  request valid; held stable by the requester while stallreq=1.
- data_sram_wen  input  4  byte write enables; 4'b0000 = read, nonzero = write.
- data_sram_addr  input  32  byte address.
- data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
- data_sram_rdata  output  32  registered read data.
- stallreq  output  1  requests a pipeline stall while a request waits.

Behaviour:
- Reset (rst=0, asynchronous): rdata=0, wait counter cnt=0, stallreq=0. Memory array is not cleared; a bench must write before it reads.
- Word index = addr[ADDR_WIDTH+1:2].
  - addr[1:0] ignored (no alignment checking).
  - Upper address bits ignored: out-of-range addresses alias.
- Wait counter cnt is 4 bits and counts 0..WAIT_CYCLES.
  - stallreq (combinational) = en && (cnt < WAIT_CYCLES).
  - Clock edge with en=1 and cnt<WAIT_CYCLES: cnt <= cnt+1. No memory access; rdata holds.
  - Clock edge with en=1 and cnt==WAIT_CYCLES: perform the access and set cnt <= 0.
  - Clock edge with en=0: cnt <= 0. A withdrawn request (flush) is discarded and performs no access.
- Timing: a request first presented in cycle T stalls cycles T..T+WAIT_CYCLES-1. The access happens at the end of cycle T+WAIT_CYCLES, and read data is valid on rdata from cycle T+WAIT_CYCLES+1. With WAIT_CYCLES=0, stallreq is constantly 0 and rdata is valid the cycle after en.
- Access rules:
  - Read (wen=0): rdata <= mem[idx].
  - Write: for each i with wen[i]=1, mem[idx] lane i <= wdata lane i. Other lanes are unchanged and rdata holds its previous value.
- rdata changes only on a performed read or on reset; otherwise it holds indefinitely. The MEM stage may stall and re-sample it.
- Back-to-back requests (en held high with changing addr, WAIT_CYCLES=0): one access per cycle.
- A read immediately after a write to the same word returns the written data (write lands at edge N, read at edge N+1).
- Reset asserted mid-wait: cnt=0, stallreq drops immediately, and no access is performed. After release, a still-asserted request restarts the full wait.
- No outputs other than stallreq are combinational from inputs.

Test Plan:
- Reset/idle: rst=0 then 1, en=0 for 5 cycles -> rdata=0 and stallreq=0 throughout.
- Word write/read, WAIT_CYCLES=0:
  - Write addr=0x10, wen=4'hF, wdata=0xDEADBEEF.
  - Next cycle read addr=0x10 -> rdata=0xDEADBEEF one cycle later; stallreq never asserted.
- Byte lanes:
  - Preload 0x11223344 at 0x20.
  - Write wen=4'b0101, wdata=0xAABBCCDD.
  - Read 0x20 -> 0x11BB33DD. Reading 0x23 (misaligned) returns the same word.
- Wait states, WAIT_CYCLES=3:
  - Read of 0x10 presented in cycle T -> stallreq=1 in T..T+2, 0 in T+3.
  - rdata=0xDEADBEEF from T+4; rdata unchanged during T..T+3.
- Flush mid-wait, WAIT_CYCLES=3:
  - Write presented 2 cycles, then en=0 -> no write (later read shows old value), cnt back to 0, stallreq=0.
- Reset mid-wait:
  - Assert rst=0 asynchronously in stall cycle 2 -> stallreq=0 and rdata=0 immediately.
  - After release with en still 1 -> 3 fresh stall cycles, then access.
